// File: rtl/binary_mul_acc_9_uni_if.sv
// Bus between the 9x9 multiplier product stream and the dot-product
// accumulator: input product handshake, clear strobe and result handshake.
//
// Handshake rule for both channels: a word moves on a rising clk edge when
// valid && ready are both high in that cycle. Once valid is raised, the
// source holds valid and its data steady until ready is seen. Ready may
// depend combinationally on the sink's state and inputs.
interface binary_mul_acc_9_uni_if #(
  parameter int PW    = 18,
  parameter int ACC_W = 21
);
  logic             clr;
  logic             in_valid;
  logic             in_ready;
  logic [PW-1:0]    in_data;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_ovf;
  logic [7:0]       frame_cnt;

  // Producer/consumer side: drives products, clr and out_ready.
  modport master (
    output clr, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf, frame_cnt
  );

  // Accumulator side.
  modport slave (
    input  clr, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum, out_ovf, frame_cnt
  );
endinterface

// File: rtl/binary_mul_acc_9_uni.sv
// Dot-product accumulator for the registered 18-bit unsigned products of the
// 9x9 array multiplier. Sums LEN consecutive products per frame and presents
// each finished sum on a valid/ready output register.
// Optional saturation on overflow: define BINARY_MUL_ACC_SAT_EN. Without it,
// the sum wraps modulo 2^ACC_W and out_ovf flags the lost carry.
module binary_mul_acc_9_uni #(
  parameter int PW    = 18,
  parameter int LEN   = 8,
  parameter int ACC_W = 21
) (
  input  logic                   clk,
  input  logic                   rst,
  binary_mul_acc_9_uni_if.slave  bus
);

  localparam int CW  = (LEN > 1) ? $clog2(LEN) : 1;
  localparam int EXT = ACC_W + 1 - PW;
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);

  logic [ACC_W-1:0] acc;
  logic [CW-1:0]    cnt;
  logic             ovf_acc;

  logic             out_valid_q;
  logic [ACC_W-1:0] out_sum_q;
  logic             out_ovf_q;
  logic [7:0]       frame_cnt_q;

  logic             in_ready_w;
  logic             accept;
  logic             at_last;
  logic             frame_end;
  logic [ACC_W:0]   data_ext;
  logic [ACC_W:0]   sum_ext;
  logic             ovf_next;
  logic [ACC_W-1:0] acc_next;

  // Stall only on the frame-final element while the result register is
  // full and not draining; clr blocks input for its cycle.
  assign at_last    = (cnt == LAST);
  assign in_ready_w = !bus.clr && !(at_last && out_valid_q && !bus.out_ready);
  assign accept     = bus.in_valid && in_ready_w;
  assign frame_end  = accept && at_last;
  assign data_ext   = {{EXT{1'b0}}, bus.in_data};

  // Next accumulator value: first element of a frame reloads, later elements
  // add with one extra bit so the carry-out is visible.
  always_comb begin
    sum_ext  = (cnt == '0) ? data_ext : ({1'b0, acc} + data_ext);
    ovf_next = (cnt == '0) ? 1'b0 : (ovf_acc | sum_ext[ACC_W]);
`ifdef BINARY_MUL_ACC_SAT_EN
    acc_next = ovf_next ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
    acc_next = sum_ext[ACC_W-1:0];
`endif
  end

  // Frame accumulation state: clr wins over accept, rst wins over both.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      cnt     <= '0;
      ovf_acc <= 1'b0;
    end else if (bus.clr) begin
      cnt     <= '0;
      ovf_acc <= 1'b0;
    end else if (accept) begin
      acc     <= acc_next;
      ovf_acc <= ovf_next;
      cnt     <= at_last ? '0 : cnt + CW'(1);
    end
  end

  // Result register: a new frame end overrides a same-cycle drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_ovf_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else if (frame_end) begin
      out_valid_q <= 1'b1;
      out_sum_q   <= acc_next;
      out_ovf_q   <= ovf_next;
      frame_cnt_q <= frame_cnt_q + 8'd1;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_ovf   = out_ovf_q;
  assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_binary_mul_acc_9_uni.sv
// Directed bench for binary_mul_acc_9_uni: one task per scenario, expected
// values computed by hand from the frame arithmetic.
module tb_binary_mul_acc_9_uni;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   exp_frames;
  logic [20:0] exp_sum20;

  binary_mul_acc_9_uni_if #(.PW(18), .ACC_W(21)) bus ();
  binary_mul_acc_9_uni_if #(.PW(18), .ACC_W(20)) bus20 ();

  binary_mul_acc_9_uni #(.PW(18), .LEN(8), .ACC_W(21)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  binary_mul_acc_9_uni #(.PW(18), .LEN(8), .ACC_W(20)) dut20 (
    .clk(clk), .rst(rst), .bus(bus20)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.in_valid = 1'b1; bus.in_data = 18'd5;
    repeat (3) step();
    rst = 1'b0; bus.in_valid = 1'b0;
    #1;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0d exp=0", bus.out_valid); end
    checks++;
    if (bus.out_sum !== 21'd0) begin failures++; $display("FAIL reset_out_sum got=%0d exp=0", bus.out_sum); end
    checks++;
    if (bus.frame_cnt !== 8'd0) begin failures++; $display("FAIL reset_frame_cnt got=%0d exp=0", bus.frame_cnt); end
    checks++;
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0d exp=1", bus.in_ready); end
    checks++;
  endtask

  task automatic test_single_frame();
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 18'(i);
      if (i == 8) begin
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid got=%0d exp=0", bus.out_valid); end
        checks++;
      end
      step();
    end
    bus.in_valid = 1'b0;
    exp_frames++;
    if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%0d exp=1", bus.out_valid); end
    checks++;
    if (bus.out_sum !== 21'd36) begin failures++; $display("FAIL single_sum got=%0d exp=36", bus.out_sum); end
    checks++;
    if (bus.out_ovf !== 1'b0) begin failures++; $display("FAIL single_ovf got=%0d exp=0", bus.out_ovf); end
    checks++;
    if (bus.frame_cnt !== 8'(exp_frames)) begin failures++; $display("FAIL single_frame_cnt got=%0d exp=%0d", bus.frame_cnt, exp_frames); end
    checks++;
    step();
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL single_valid_one_cycle got=%0d exp=0", bus.out_valid); end
    checks++;
  endtask

  task automatic test_full_scale();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 18'd261121;
      step();
    end
    bus.in_valid = 1'b0;
    exp_frames++;
    if (bus.out_sum !== 21'd2088968) begin failures++; $display("FAIL full_sum got=%0d exp=2088968", bus.out_sum); end
    checks++;
    if (bus.out_ovf !== 1'b0) begin failures++; $display("FAIL full_ovf got=%0d exp=0", bus.out_ovf); end
    checks++;
    if (bus.frame_cnt !== 8'(exp_frames)) begin failures++; $display("FAIL full_frame_cnt got=%0d exp=%0d", bus.frame_cnt, exp_frames); end
    checks++;
    step();
  endtask

  // Frame A = 1..8 (36) immediately followed by frame B = 8 x 10 (80).
  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 8; i++) begin
        bus.in_valid = 1'b1;
        bus.in_data  = (f == 0) ? 18'(i + 1) : 18'd10;
        #1;
        if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready f=%0d i=%0d got=%0d exp=1", f, i, bus.in_ready); end
        checks++;
        step();
        if (f == 1 && i == 0) begin
          if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drained got=%0d exp=0", bus.out_valid); end
          checks++;
        end
      end
      exp_frames++;
      if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid f=%0d got=%0d exp=1", f, bus.out_valid); end
      checks++;
      if (bus.out_sum !== ((f == 0) ? 21'd36 : 21'd80)) begin failures++; $display("FAIL b2b_sum f=%0d got=%0d exp=%0d", f, bus.out_sum, (f == 0) ? 36 : 80); end
      checks++;
    end
    bus.in_valid = 1'b0;
    if (bus.frame_cnt !== 8'(exp_frames)) begin failures++; $display("FAIL b2b_frame_cnt got=%0d exp=%0d", bus.frame_cnt, exp_frames); end
    checks++;
    step();
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    for (int e = 1; e <= 15; e++) begin
      bus.in_valid = 1'b1; bus.in_data = 18'd100;
      #1;
      if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_in_ready e=%0d got=%0d exp=1", e, bus.in_ready); end
      checks++;
      if (e >= 10) begin
        if (bus.out_valid !== 1'b1 || bus.out_sum !== 21'd800) begin
          failures++; $display("FAIL bp_hold e=%0d valid=%0d sum=%0d exp valid=1 sum=800", e, bus.out_valid, bus.out_sum);
        end
        checks++;
      end
      step();
    end
    exp_frames++;
    bus.in_valid = 1'b1; bus.in_data = 18'd100;
    for (int k = 0; k < 3; k++) begin
      #1;
      if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_stall k=%0d got=%0d exp=0", k, bus.in_ready); end
      checks++;
      if (bus.out_sum !== 21'd800 || bus.frame_cnt !== 8'(exp_frames)) begin
        failures++; $display("FAIL bp_stall_hold k=%0d sum=%0d cnt=%0d exp sum=800 cnt=%0d", k, bus.out_sum, bus.frame_cnt, exp_frames);
      end
      checks++;
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%0d exp=1", bus.in_ready); end
    checks++;
    step();
    bus.in_valid = 1'b0;
    exp_frames++;
    if (bus.out_valid !== 1'b1 || bus.out_sum !== 21'd800) begin
      failures++; $display("FAIL bp_second valid=%0d sum=%0d exp valid=1 sum=800", bus.out_valid, bus.out_sum);
    end
    checks++;
    if (bus.frame_cnt !== 8'(exp_frames)) begin failures++; $display("FAIL bp_frame_cnt got=%0d exp=%0d", bus.frame_cnt, exp_frames); end
    checks++;
    step();
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%0d exp=0", bus.out_valid); end
    checks++;
  endtask

  task automatic test_clr();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 18'd7;
      step();
    end
    bus.clr = 1'b1; bus.in_data = 18'd9;
    #1;
    if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL clr_in_ready got=%0d exp=0", bus.in_ready); end
    checks++;
    step();
    bus.clr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.in_data = 18'd2;
      step();
      if (i < 7) begin
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL clr_early_valid i=%0d got=%0d exp=0", i, bus.out_valid); end
        checks++;
      end
    end
    bus.in_valid = 1'b0;
    exp_frames++;
    if (bus.out_valid !== 1'b1 || bus.out_sum !== 21'd16) begin
      failures++; $display("FAIL clr_sum valid=%0d sum=%0d exp valid=1 sum=16", bus.out_valid, bus.out_sum);
    end
    checks++;
    if (bus.out_ovf !== 1'b0) begin failures++; $display("FAIL clr_ovf got=%0d exp=0", bus.out_ovf); end
    checks++;
    if (bus.frame_cnt !== 8'(exp_frames)) begin failures++; $display("FAIL clr_frame_cnt got=%0d exp=%0d", bus.frame_cnt, exp_frames); end
    checks++;
    step();
  endtask

  // ACC_W=20 instance: overflowing frame, then a small frame to confirm the
  // overflow flag does not leak into the next frame.
  task automatic test_overflow();
`ifdef BINARY_MUL_ACC_SAT_EN
    exp_sum20 = 21'd1048575;
`else
    exp_sum20 = 21'd1040392;
`endif
    bus20.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus20.in_valid = 1'b1; bus20.in_data = 18'd261121;
      step();
    end
    bus20.in_valid = 1'b0;
    if (bus20.out_valid !== 1'b1 || {1'b0, bus20.out_sum} !== exp_sum20) begin
      failures++; $display("FAIL ovf_sum valid=%0d sum=%0d exp valid=1 sum=%0d", bus20.out_valid, bus20.out_sum, exp_sum20);
    end
    checks++;
    if (bus20.out_ovf !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%0d exp=1", bus20.out_ovf); end
    checks++;
    if (bus20.frame_cnt !== 8'd1) begin failures++; $display("FAIL ovf_frame_cnt got=%0d exp=1", bus20.frame_cnt); end
    checks++;
    for (int i = 1; i <= 8; i++) begin
      bus20.in_valid = 1'b1; bus20.in_data = 18'(i);
      step();
    end
    bus20.in_valid = 1'b0;
    if (bus20.out_sum !== 20'd36 || bus20.out_ovf !== 1'b0) begin
      failures++; $display("FAIL ovf_next_frame sum=%0d ovf=%0d exp sum=36 ovf=0", bus20.out_sum, bus20.out_ovf);
    end
    checks++;
    step();
  endtask

  initial begin
    checks = 0; failures = 0; exp_frames = 0;
    rst = 1'b1;
    bus.clr = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
    bus20.clr = 1'b0; bus20.in_valid = 1'b0; bus20.in_data = '0; bus20.out_ready = 1'b1;
    test_reset();
    test_single_frame();
    test_full_scale();
    test_back_to_back();
    test_backpressure();
    test_clr();
    test_overflow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/binary_mul_acc_9_uni.md
Name: binary_mul_acc_9_uni

Overview:
- Downstream consumer of the registered 18-bit unsigned product of the 9x9 array multiplier.
- Accumulates LEN consecutive products into one unsigned dot-product sum.
- Presents each finished sum on a valid/ready output register.
- Provides backpressure to the multiplier side through in_ready.

Parameters:
- PW, 18: product input width; matches the multiplier P width.
- LEN, 8: number of products per frame; must be >= 2.
- ACC_W, 21: accumulator and sum width; must be >= PW. The default is lossless for LEN=8 full-scale 9x9 products (8*511*511 = 2088968 < 2^21).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- clr  input  1  synchronous discard of the partial frame.
- in_valid  input  1  in_data holds a product this cycle.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  PW  unsigned product.
- out_valid  output  1  out_sum and out_ovf hold a finished frame.
- out_ready  input  1  consumer takes the output this cycle.
- out_sum  output  ACC_W  finished frame sum.
- out_ovf  output  1  frame exceeded 2^ACC_W-1.
- frame_cnt  output  8  number of frames completed since reset; wraps 255->0.

Behaviour:
- Interface: single clock clk; reset rst is synchronous and active-high. All state updates on the rising edge of clk.
- Reset: acc=0, cnt=0, ovf_acc=0, out_valid=0, out_sum=0, out_ovf=0, frame_cnt=0. Reset mid-frame drops the partial frame and any pending output.
- Accept: accept = in_valid && in_ready.
- Internal state: acc (ACC_W bits), element counter cnt (0..LEN-1, width clog2(LEN)), sticky ovf_acc.
- On accept when cnt==0: acc <= zero-extended in_data; ovf_acc <= 0.
- On accept when cnt>0: acc <= acc + in_data at ACC_W+1 bits. ovf_acc is set if the carry-out is 1. The stored value follows the overflow rule below.
- Mid-frame accept (cnt<LEN-1): cnt <= cnt+1.
- Frame-end accept (cnt==LEN-1):
  - out_sum <= final sum (same add rule as above); out_ovf <= final ovf.
  - out_valid <= 1; cnt <= 0; frame_cnt <= frame_cnt+1.
  - acc is not required to hold a defined value afterwards; the next frame reloads it.
- Latency: out_valid asserts one cycle after the accept of the LEN-th product.
- Output handshake:
  - out_valid && out_ready clears out_valid next cycle, unless a new frame-end accept happens in that same cycle. In that case out_valid stays 1 and out_sum/out_ovf load the new frame.
  - out_sum and out_ovf are stable while out_valid && !out_ready.
- in_ready = !clr && !(cnt==LEN-1 && out_valid && !out_ready).
  - Input stalls only at the frame-final element when the output register is full and not draining.
  - Back-to-back frames run at one product per cycle when out_ready is held high.
- clr: cnt <= 0 and ovf_acc <= 0; same-cycle in_data is not accepted (in_ready=0). The output register and frame_cnt are unaffected.
- rst has priority over clr; clr has priority over accept.
- Overflow rule, default (macro absent): sum wraps modulo 2^ACC_W; out_ovf reports whether any carry was lost in the frame.

Optional Feature:
- Macro BINARY_MUL_ACC_SAT_EN.
- Defined:
  - Any carry-out clamps acc to 2^ACC_W-1, and acc stays there for the rest of the frame.
  - out_sum = 2^ACC_W-1 and out_ovf = 1 for that frame.
- Undefined: wrap-around behaviour as stated above. No saturation logic is synthesised.

Test Plan:
- Reset check: hold rst high 3 cycles with in_valid=1 and in_data=5 → after release, out_valid=0, out_sum=0, frame_cnt=0, in_ready=1.
- Single frame: LEN=8, out_ready=1, feed products 1..8 on consecutive cycles → one cycle after the 8th accept, out_valid=1 for exactly one cycle, out_sum=36, out_ovf=0, frame_cnt=1.
- Full scale: 8 x 261121 → out_sum=2088968, out_ovf=0.
- Backpressure: out_ready=0, feed two frames of all 100 back-to-back:
  - first out_sum=800 is held stable;
  - in_ready drops only when the 16th element is presented;
  - raise out_ready → first sum is taken, 16th element is accepted, and next cycle out_sum=800 again with frame_cnt=2.
- clr mid-frame: 3 products of 7, then clr together with in_valid (data 9), then 8 products of 2 → the 9 is not accepted; out_sum=16; frame_cnt increments by 1 only.
- Overflow with ACC_W=20, 8 x 261121 (2088968):
  - macro absent: out_sum = 2088968 - 1048576 = 1040392, out_ovf=1;
  - BINARY_MUL_ACC_SAT_EN defined: out_sum = 1048575, out_ovf=1.
